correlate_bank_matcher: RTL and testbench

- Parametrised template matcher for the voice-command path.
- Computes the zero-lag correlation (dot product) of one captured audio window against each of NUM_TEMPLATES stored templates, one multiply-accumulate per cycle.
- Reports the best-scoring template index and score, and whether that score meets a runtime threshold.
- Sits between the window capture buffer and the command decoder. Generalises the fixed 4-sample, single-result compare to any window length and template count, with best-match selection.

---
 rtl/correlate_bank_matcher_if.sv | 30 +++
 rtl/correlate_bank_matcher.sv | 108 ++++++++++
 tb/tb_correlate_bank_matcher.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/correlate_bank_matcher_if.sv
// correlate_bank_matcher_if: window/template read ports, run control and match results
interface correlate_bank_matcher_if #(
  parameter int SAMPLE_W      = 10,
  parameter int WIN_LEN       = 16,
  parameter int NUM_TEMPLATES = 4,
  parameter int ACC_W         = 24
);
  localparam int AW = WIN_LEN > 1 ? $clog2(WIN_LEN) : 1;
  localparam int TW = NUM_TEMPLATES > 1 ? $clog2(NUM_TEMPLATES) : 1;
  localparam int BW = NUM_TEMPLATES * WIN_LEN > 1 ? $clog2(NUM_TEMPLATES * WIN_LEN) : 1;
  logic             start;
  logic [ACC_W-1:0] threshold;
  logic [AW-1:0]    win_addr;
  logic [SAMPLE_W-1:0] win_data;
  logic [BW-1:0]    bank_addr;
  logic [SAMPLE_W-1:0] bank_data;
  logic             busy;
  logic             done;
  logic             match;
  logic [TW-1:0]    best_idx;
  logic [ACC_W-1:0] best_score;
  modport master (
    output start, threshold, win_data, bank_data,
    input  win_addr, bank_addr, busy, done, match, best_idx, best_score
  );
  modport slave (
    input  start, threshold, win_data, bank_data,
    output win_addr, bank_addr, busy, done, match, best_idx, best_score
  );
endinterface

// File: rtl/correlate_bank_matcher.sv
// correlate_bank_matcher: zero-lag correlation of one window against a template bank, best-match select
module correlate_bank_matcher #(
  parameter int SAMPLE_W      = 10,
  parameter int WIN_LEN       = 16,
  parameter int NUM_TEMPLATES = 4,
  parameter int ACC_W         = 24
) (
  input logic clk,
  input logic reset,
  correlate_bank_matcher_if.slave bus
);
  localparam int AW = WIN_LEN > 1 ? $clog2(WIN_LEN) : 1;
  localparam int TW = NUM_TEMPLATES > 1 ? $clog2(NUM_TEMPLATES) : 1;
  localparam int BW = NUM_TEMPLATES * WIN_LEN > 1 ? $clog2(NUM_TEMPLATES * WIN_LEN) : 1;
  typedef enum logic [2:0] {IDLE, RUN, LAST, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [TW-1:0] t_q, t_d, run_idx_q, run_idx_d, best_idx_q, best_idx_d, new_idx;
  logic valid_q, valid_d, match_q, match_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, thr_q, thr_d, run_best_q, run_best_d;
  logic signed [ACC_W-1:0] best_score_q, best_score_d, new_best, prod_x;
  logic signed [2*SAMPLE_W-1:0] prod;
  assign prod = $signed(bus.win_data) * $signed(bus.bank_data);
  assign prod_x = ACC_W'(prod);
  // strict compare so that ties keep the lower template index
  assign new_best = acc_q > run_best_q ? acc_q : run_best_q;
  assign new_idx = acc_q > run_best_q ? t_q : run_idx_q;
  assign bus.win_addr = i_q;
  assign bus.bank_addr = BW'(t_q) * BW'(WIN_LEN) + BW'(i_q);
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.match = match_q;
  assign bus.best_idx = best_idx_q;
  assign bus.best_score = best_score_q;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    t_d = t_q;
    thr_d = thr_q;
    run_best_d = run_best_q;
    run_idx_d = run_idx_q;
    best_score_d = best_score_q;
    best_idx_d = best_idx_q;
    match_d = match_q;
    valid_d = state_q == RUN;
    acc_d = valid_q ? acc_q + prod_x : acc_q;
    case (state_q)
      IDLE: if (bus.start) begin
        thr_d = $signed(bus.threshold);
        i_d = '0;
        t_d = '0;
        acc_d = '0;
        run_best_d = {1'b1, {(ACC_W-1){1'b0}}};
        run_idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        state_d = i_q == AW'(WIN_LEN - 1) ? LAST : RUN;
        i_d = i_q == AW'(WIN_LEN - 1) ? i_q : i_q + AW'(1);
      end
      LAST: state_d = CMP;
      CMP: begin
        run_best_d = new_best;
        run_idx_d = new_idx;
        acc_d = '0;
        i_d = '0;
        if (t_q == TW'(NUM_TEMPLATES - 1)) begin
          best_score_d = new_best;
          best_idx_d = new_idx;
          match_d = new_best >= thr_q;
          state_d = DONE;
        end else begin
          t_d = t_q + TW'(1);
          state_d = RUN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q <= '0;
      t_q <= '0;
      valid_q <= 1'b0;
      acc_q <= '0;
      thr_q <= '0;
      run_best_q <= '0;
      run_idx_q <= '0;
      best_score_q <= '0;
      best_idx_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      t_q <= t_d;
      valid_q <= valid_d;
      acc_q <= acc_d;
      thr_q <= thr_d;
      run_best_q <= run_best_d;
      run_idx_q <= run_idx_d;
      best_score_q <= best_score_d;
      best_idx_q <= best_idx_d;
      match_q <= match_d;
    end
  end
endmodule

// File: tb/tb_correlate_bank_matcher.sv
// tb_correlate_bank_matcher: directed runs checked every cycle against a dot-product model
module tb_correlate_bank_matcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  correlate_bank_matcher_if #(.SAMPLE_W(10), .WIN_LEN(16), .NUM_TEMPLATES(4), .ACC_W(24)) bus();
  correlate_bank_matcher #(.SAMPLE_W(10), .WIN_LEN(16), .NUM_TEMPLATES(4), .ACC_W(24)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  logic signed [9:0] win_mem [16];
  logic signed [9:0] bank_mem [64];
  int total = 0;
  int bad = 0;
  int rem = 0;
  int p_idx = 0, p_score = 0, e_idx = 0, e_score = 0;
  bit p_match = 1'b0, e_match = 1'b0;
  int c_idx, c_score, lat;
  // synchronous ROMs: data follows the address by one cycle
  always @(posedge clk) begin
    bus.win_data <= win_mem[bus.win_addr];
    bus.bank_data <= bank_mem[bus.bank_addr];
  end
  function automatic int score(input int t);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(win_mem[k]) * int'(bank_mem[t*16+k]);
    return s;
  endfunction
  always_comb begin
    c_idx = 0;
    c_score = score(0);
    for (int t = 1; t < 4; t++) if (score(t) > c_score) begin
      c_idx = t;
      c_score = score(t);
    end
  end
  // run model: busy for 73 cycles after an accepted start, results appear with done
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= 0;
      e_idx <= 0;
      e_score <= 0;
      e_match <= 1'b0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 2) begin
        e_idx <= p_idx;
        e_score <= p_score;
        e_match <= p_match;
      end
    end else if (bus.start) begin
      rem <= 73;
      p_idx <= c_idx;
      p_score <= c_score;
      p_match <= c_score >= int'($signed(bus.threshold));
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("busy", int'(bus.busy), int'(rem > 0));
    chk("done", int'(bus.done), int'(rem == 1));
    chk("best_idx", int'(bus.best_idx), e_idx);
    chk("best_score", int'($signed(bus.best_score)), e_score);
    chk("match", int'(bus.match), int'(e_match));
  end
  task automatic run(input logic [23:0] thr, input bit pulse, output int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.threshold = thr;
    @(posedge clk);
    l = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && l < 200) begin
      @(posedge clk);
      l++;
      @(negedge clk);
      bus.start = pulse && (l == 10 || l == 71);
    end
    bus.start = 1'b0;
  endtask
  task automatic load_pattern();
    for (int k = 0; k < 16; k++) begin
      win_mem[k] = 10'(k - 8);
      bank_mem[k] = 10'sd1;
      bank_mem[16+k] = 10'(7 - k);
      bank_mem[32+k] = 10'(k - 8);
      bank_mem[48+k] = (k % 2 == 1) ? 10'sd5 : -10'sd5;
    end
  endtask
  task automatic expect_result(input string tag, input int idx, input int sc, input int m);
    chk({tag, "_latency"}, lat, 72);
    chk({tag, "_idx"}, int'(bus.best_idx), idx);
    chk({tag, "_score"}, int'($signed(bus.best_score)), sc);
    chk({tag, "_match"}, int'(bus.match), m);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.threshold = '0;
    for (int k = 0; k < 16; k++) win_mem[k] = '0;
    for (int k = 0; k < 64; k++) bank_mem[k] = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    chk("reset_idx", int'(bus.best_idx), 0);
    chk("reset_score", int'($signed(bus.best_score)), 0);
    load_pattern();
    run(24'd0, 1'b0, lat);
    expect_result("exact", 2, 344, 1);
    for (int k = 0; k < 16; k++) win_mem[k] = '0;
    run(24'd1, 1'b0, lat);
    expect_result("zero_thr1", 0, 0, 0);
    run(24'd0, 1'b0, lat);
    expect_result("zero_thr0", 0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      win_mem[k] = -10'sd512;
      bank_mem[k] = 10'sd511;
      bank_mem[16+k] = -10'sd512;
      bank_mem[32+k] = 10'sd511;
      bank_mem[48+k] = 10'sd511;
    end
    run(24'd0, 1'b0, lat);
    expect_result("extreme", 1, 4194304, 1);
    for (int k = 0; k < 16; k++) begin
      bank_mem[k] = '0;
      bank_mem[16+k] = '0;
      bank_mem[32+k] = '0;
    end
    run(24'd0, 1'b0, lat);
    expect_result("neg_only", 0, 0, 1);
    load_pattern();
    run(24'h7FFFFF, 1'b0, lat);
    expect_result("high_thr", 2, 344, 0);
    run(24'd0, 1'b1, lat);
    expect_result("restart_ignored", 2, 344, 1);
    run(24'd0, 1'b0, lat);
    expect_result("after_pulses", 2, 344, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.threshold = 24'hFFFFF0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_match", int'(bus.match), 0);
    chk("arst_idx", int'(bus.best_idx), 0);
    chk("arst_score", int'($signed(bus.best_score)), 0);
    chk("arst_win_addr", int'(bus.win_addr), 0);
    chk("arst_bank_addr", int'(bus.bank_addr), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    run(24'd0, 1'b0, lat);
    expect_result("post_reset", 2, 344, 1);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
